lcd_hex_arbiter: RTL and testbench

Shares the 16x2 character LCD's memory write port (data, enable, pos, row) between several requesters. Each requester displays a 32-bit value as 8 uppercase hex characters. The block arbitrates round-robin, formats the value as ASCII, and streams one character per cycle into the display's character memory. It sits between status sources (loopback counters, throughput monitors) and the LCD driver, on the same fast clock as the LCD memory write side.

---
 rtl/lcd_hex_arbiter.sv | 160 ++++++++++++++++
 tb/tb_lcd_hex_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_hex_arbiter.sv
// Round-robin arbiter that formats a requester's 32-bit value as 8 hex characters for the 16x2 LCD.
// Optional build macro LCD_HEXARB_ZERO_BLANK_EN replaces leading zero digits with spaces.
module lcd_hex_arbiter #(
    parameter int NREQ = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NREQ-1:0]      req_i,
    input  logic [32*NREQ-1:0]   req_value_i,
    input  logic [NREQ-1:0]      req_row_i,
    input  logic [4*NREQ-1:0]    req_pos_i,
    output logic [NREQ-1:0]      ack_o,
    output logic                 busy_o,
    output logic [7:0]           out_data_o,
    output logic                 out_enable_o,
    output logic [3:0]           out_pos_o,
    output logic                 out_row_o
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_grant_q, last_grant_d;
    logic [31:0]     value_q, value_d;
    logic            row_q, row_d;
    logic [3:0]      pos_q, pos_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            busy_q, busy_d;
    logic [7:0]      data_q, data_d;
    logic            enable_q, enable_d;
    logic [3:0]      opos_q, opos_d;
    logic            orow_q, orow_d;
    logic [GW-1:0]   win;

    // First requesting index found when scanning upward from last + 1, wrapping at NREQ.
    function automatic logic [GW-1:0] pick_winner(input logic [NREQ-1:0] req,
                                                  input logic [GW-1:0]   last);
        logic [GW-1:0] result;
        logic          found;
        int            j;
        result = '0;
        found  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(last) + 1 + i;
            if (j >= NREQ) j = j - NREQ;
            if (!found && req[j]) begin
                found  = 1'b1;
                result = GW'(j);
            end
        end
        return result;
    endfunction

    function automatic logic [7:0] hex_char(input logic [31:0] value, input logic [2:0] idx);
        logic [4:0] lsb;
        logic [3:0] nib;
        lsb = 5'd28 - {idx, 2'b00};
        nib = value[lsb +: 4];
`ifdef LCD_HEXARB_ZERO_BLANK_EN
        // Digit idx is blank when it and every digit above it are zero; the last digit always prints.
        if (idx != 3'd7 && (value >> lsb) == 32'd0) return 8'h20;
`endif
        if (nib < 4'd10) return 8'h30 + {4'h0, nib};
        return 8'h37 + {4'h0, nib};
    endfunction

    // Outputs are derived from the next-state values so that the first character
    // appears in the cycle right after the grant, with no req-to-output path.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        value_d      = value_q;
        row_d        = row_q;
        pos_d        = pos_q;
        win          = pick_winner(req_i, last_grant_q);

        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    grant_d = win;
                    value_d = req_value_i[32*win +: 32];
                    row_d   = req_row_i[win];
                    pos_d   = req_pos_i[4*win +: 4];
                    cnt_d   = 3'd0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (cnt_q == 3'd7) begin
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ACK: begin
                last_grant_d = grant_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        enable_d = (state_d == WRITE);
        busy_d   = (state_d != IDLE);
        data_d   = enable_d ? hex_char(value_d, cnt_d) : 8'h00;
        opos_d   = enable_d ? (pos_d + {1'b0, cnt_d}) : 4'h0;
        orow_d   = enable_d & row_d;
        ack_d    = '0;
        if (state_d == ACK) ack_d[grant_d] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            grant_q      <= '0;
            last_grant_q <= GW'(NREQ - 1);
            value_q      <= 32'd0;
            row_q        <= 1'b0;
            pos_q        <= 4'd0;
            ack_q        <= '0;
            busy_q       <= 1'b0;
            data_q       <= 8'h00;
            enable_q     <= 1'b0;
            opos_q       <= 4'd0;
            orow_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            value_q      <= value_d;
            row_q        <= row_d;
            pos_q        <= pos_d;
            ack_q        <= ack_d;
            busy_q       <= busy_d;
            data_q       <= data_d;
            enable_q     <= enable_d;
            opos_q       <= opos_d;
            orow_q       <= orow_d;
        end
    end

    assign ack_o        = ack_q;
    assign busy_o       = busy_q;
    assign out_data_o   = data_q;
    assign out_enable_o = enable_q;
    assign out_pos_o    = opos_q;
    assign out_row_o    = orow_q;

endmodule

// File: tb/tb_lcd_hex_arbiter.sv
// Testbench for lcd_hex_arbiter: transaction-level reference model plus literal directed cases.
// Honours LCD_HEXARB_ZERO_BLANK_EN when it is defined for the build.
module tb_lcd_hex_arbiter;

    localparam int NREQ = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req;
    logic [32*NREQ-1:0]  reqValue;
    logic [NREQ-1:0]     reqRow;
    logic [4*NREQ-1:0]   reqPos;
    logic [NREQ-1:0]     ack;
    logic                busy;
    logic [7:0]          outData;
    logic                outEnable;
    logic [3:0]          outPos;
    logic                outRow;

    int testsRun = 0;
    int testsFailed = 0;

    lcd_hex_arbiter #(.NREQ(NREQ)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_i        (req),
        .req_value_i  (reqValue),
        .req_row_i    (reqRow),
        .req_pos_i    (reqPos),
        .ack_o        (ack),
        .busy_o       (busy),
        .out_data_o   (outData),
        .out_enable_o (outEnable),
        .out_pos_o    (outPos),
        .out_row_o    (outRow)
    );

    always #5 clk = ~clk;

    // Reference model: a transaction is a 10-cycle timeline counted from the grant edge.
    int          mPhase;
    int          mGrant;
    int          mLast;
    int          mCand;
    logic        mFound;
    logic [31:0] mValue;
    logic        mRow;
    int          mPos;
    string       mText;

    function automatic string formatHex(input logic [31:0] v);
        string digits;
        string s;
        logic  leading;
        digits = "0123456789ABCDEF";
        s = "00000000";
        for (int k = 0; k < 8; k++)
            s.putc(k, digits.getc(int'((v >> (28 - 4 * k)) & 32'hF)));
`ifdef LCD_HEXARB_ZERO_BLANK_EN
        leading = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (leading && s.getc(k) == 8'h30) s.putc(k, 8'h20);
            else leading = 1'b0;
        end
`else
        leading = 1'b0;
`endif
        return s;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mPhase = 0;
            mGrant = 0;
            mLast  = NREQ - 1;
            mText  = "00000000";
        end else if (mPhase == 0) begin
            if (req != '0) begin
                mFound = 1'b0;
                for (int i = 1; i <= NREQ; i++) begin
                    mCand = (mLast + i) % NREQ;
                    if (!mFound && req[mCand]) begin
                        mFound = 1'b1;
                        mGrant = mCand;
                    end
                end
                mValue = reqValue[32*mGrant +: 32];
                mRow   = reqRow[mGrant];
                mPos   = int'(reqPos[4*mGrant +: 4]);
                mText  = formatHex(mValue);
                mPhase = 1;
            end
        end else if (mPhase == 9) begin
            mLast  = mGrant;
            mPhase = 0;
        end else begin
            mPhase = mPhase + 1;
        end
    end

    // Every cycle, compare the DUT against the model's view of the current timeline.
    logic            expEn, expBusy, cmpOk;
    logic [NREQ-1:0] expAck;
    logic [7:0]      expData;
    logic [3:0]      expPos;

    always @(negedge clk) begin
        expEn   = (mPhase >= 1 && mPhase <= 8);
        expBusy = (mPhase != 0);
        expAck  = '0;
        if (mPhase == 9) expAck[mGrant] = 1'b1;
        expData = expEn ? mText.getc(mPhase - 1) : 8'h00;
        expPos  = 4'(mPos + mPhase - 1);
        cmpOk   = (outEnable === expEn) && (busy === expBusy) && (ack === expAck);
        if (expEn) cmpOk = cmpOk && (outData === expData) && (outPos === expPos) && (outRow === mRow);
        testsRun++;
        if (!cmpOk) begin
            testsFailed++;
            $display("[TB] FAIL model t=%0t: got en=%b busy=%b ack=%b data=%h pos=%0d row=%b, required en=%b busy=%b ack=%b data=%h pos=%0d row=%b",
                     $time, outEnable, busy, ack, outData, outPos, outRow,
                     expEn, expBusy, expAck, expData, expPos, mRow);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    // One request on requester idx from idle; chars and positions are literal expectations.
    task automatic runLiteral(input string name, input int idx, input logic [31:0] value,
                              input logic row, input logic [3:0] pos,
                              input logic [63:0] expChars, input logic [31:0] expPosSeq,
                              input int dropAt);
        logic [NREQ-1:0] oneHot;
        oneHot = '0;
        oneHot[idx] = 1'b1;
        @(negedge clk);
        reqValue[32*idx +: 32] = value;
        reqRow[idx] = row;
        reqPos[4*idx +: 4] = pos;
        req[idx] = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k <= 8) begin
                checkOutput({name, " enable"}, outEnable, 1);
                checkOutput({name, " data"}, outData, expChars[63 - 8*(k-1) -: 8]);
                checkOutput({name, " pos"}, outPos, expPosSeq[31 - 4*(k-1) -: 4]);
                checkOutput({name, " row"}, outRow, row);
            end else begin
                checkOutput({name, " ack"}, ack, oneHot);
                checkOutput({name, " enable after"}, outEnable, 0);
            end
            if (k == dropAt || k == 9) req[idx] = 1'b0;
        end
    endtask

    task automatic drain();
        req = '0;
        repeat (12) @(negedge clk);
        checkOutput("drain busy", busy, 0);
    endtask

    function automatic logic [31:0] pickValue();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 255));
            2:       return 32'd0;
            default: return $urandom >> $urandom_range(0, 31);
        endcase
    endfunction

    task automatic applyStimulus();
        for (int i = 0; i < NREQ; i++) begin
            if (!req[i]) begin
                if ($urandom_range(0, 3) == 0) begin
                    reqValue[32*i +: 32] = pickValue();
                    reqRow[i] = 1'($urandom_range(0, 1));
                    reqPos[4*i +: 4] = 4'($urandom_range(0, 15));
                    req[i] = 1'b1;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                req[i] = 1'b0;
            end
        end
    endtask

    int ackCount;

    initial begin
        rst_n = 1'b0;
        req = '0;
        reqValue = '0;
        reqRow = '0;
        reqPos = '0;
        #1;
        checkOutput("reset enable", outEnable, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset ack", ack, 0);
        checkOutput("reset data", outData, 8'h00);
        checkOutput("reset pos", outPos, 0);
        checkOutput("reset row", outRow, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        runLiteral("single", 0, 32'h1234ABCD, 1'b0, 4'd0, 64'h31323334_41424344, 32'h01234567, 0);
        drain();
        runLiteral("wrap", 0, 32'hDEADBEEF, 1'b1, 4'd12, 64'h44454144_42454546, 32'hCDEF0123, 0);
        drain();
`ifdef LCD_HEXARB_ZERO_BLANK_EN
        runLiteral("drop", 1, 32'h0F00CAFE, 1'b0, 4'd5, 64'h20463030_43414645, 32'h56789ABC, 3);
        drain();
        runLiteral("blank A5", 0, 32'h000000A5, 1'b0, 4'd0, 64'h20202020_20204135, 32'h01234567, 0);
        drain();
        runLiteral("blank zero", 0, 32'h00000000, 1'b1, 4'd8, 64'h20202020_20202030, 32'h89ABCDEF, 0);
        drain();
`else
        runLiteral("drop", 1, 32'h0F00CAFE, 1'b0, 4'd5, 64'h30463030_43414645, 32'h56789ABC, 3);
        drain();
        runLiteral("digits A5", 0, 32'h000000A5, 1'b0, 4'd0, 64'h30303030_30304135, 32'h01234567, 0);
        drain();
        runLiteral("digits zero", 0, 32'h00000000, 1'b1, 4'd8, 64'h30303030_30303030, 32'h89ABCDEF, 0);
        drain();
`endif

        // Reset in the middle of a write, then both requesters held high.
        @(negedge clk);
        reqValue[63:32] = 32'h55667788;
        req[1] = 1'b1;
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async reset enable", outEnable, 0);
        checkOutput("async reset busy", busy, 0);
        checkOutput("async reset ack", ack, 0);
        req = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        reqValue = {32'h22222222, 32'h11111111};
        reqRow = '0;
        reqPos = '0;
        req = 2'b11;
        ackCount = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (ack != '0) ackCount++;
            if (k % 10 >= 1 && k % 10 <= 8)
                checkOutput("rr data", outData, ((k / 10) % 2 == 0) ? 8'h31 : 8'h32);
            else if (k % 10 == 9)
                checkOutput("rr ack", ack, ((k / 10) % 2 == 0) ? 2'b01 : 2'b10);
            else
                checkOutput("rr idle gap busy", busy, 0);
        end
        checkOutput("rr ack count", ackCount, 3);
        drain();

        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            applyStimulus();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
